// File: rtl/approx_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : approx_mac_pkg
// Purpose  : Shared types and defaults for the approximate-MAC accumulator:
//            FSM state encoding, default widths and the counter-width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package approx_mac_pkg;

    localparam int c_prod_w    = 16;
    localparam int c_acc_w     = 24;
    localparam int c_max_terms = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // clog2(max_terms)+1 so the counter can hold the value max_terms itself.
    function automatic int cnt_width(input int max_terms);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < max_terms) begin
                w = i + 1;
            end
        end
        return w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_add_u.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_u
// Purpose  : Combinational unsigned saturating adder. b is zero-extended to
//            the width of a; on carry-out the sum clamps to all ones.
// Ports    : a   [A_W-1:0] in   augend
//            b   [B_W-1:0] in   addend (B_W <= A_W)
//            sum [A_W-1:0] out  saturated sum
//            ovf           out  carry-out occurred (sum clamped)
// Revision : 1.0 - initial release
// ============================================================================
module sat_add_u #(
    parameter int A_W = 24,
    parameter int B_W = 16
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           ovf
);

    logic [A_W:0] w_full;

    assign w_full = {1'b0, a} + (A_W + 1)'(b);
    assign ovf    = w_full[A_W];
    assign sum    = w_full[A_W] ? {A_W{1'b1}} : w_full[A_W-1:0];

endmodule
`default_nettype wire

// File: rtl/approx_mac_accum.sv
`default_nettype none
// ============================================================================
// Module   : approx_mac_accum
// Purpose  : Streaming packet accumulator for approximate-multiplier products.
//            Sums one product per cycle until p_last (or MAX_TERMS beats),
//            then presents the saturated sum, beat count and flags on a
//            registered valid/ready output.
// Ports    : clk, rst            clock, synchronous active-high reset
//            p_valid/p_ready     product beat handshake
//            p_data [PROD_W]     unsigned product
//            p_last              final beat of packet
//            s_valid/s_ready     result handshake
//            s_sum  [ACC_W]      saturated packet sum
//            s_count[CNT_W]      beats in packet (1..MAX_TERMS)
//            s_sat               sum saturated during packet
//            s_trunc             packet closed at MAX_TERMS without p_last
// Revision : 1.0 - initial release
// ============================================================================
module approx_mac_accum
    import approx_mac_pkg::*;
#(
    parameter int PROD_W    = c_prod_w,
    parameter int ACC_W     = c_acc_w,
    parameter int MAX_TERMS = c_max_terms,
    localparam int CNT_W    = cnt_width(MAX_TERMS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    output logic              p_ready,
    input  logic [PROD_W-1:0] p_data,
    input  logic              p_last,
    output logic              s_valid,
    input  logic              s_ready,
    output logic [ACC_W-1:0]  s_sum,
    output logic [CNT_W-1:0]  s_count,
    output logic              s_sat,
    output logic              s_trunc
);

    localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(MAX_TERMS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;

    logic              r_s_valid;
    logic [ACC_W-1:0]  r_s_sum;
    logic [CNT_W-1:0]  r_s_count;
    logic              r_s_sat;
    logic              r_s_trunc;

    logic              w_accept;
    logic              w_start;
    logic              w_close;
    logic [ACC_W-1:0]  w_base_acc;
    logic [CNT_W-1:0]  w_base_cnt;
    logic              w_base_sat;
    logic [ACC_W-1:0]  w_sum;
    logic              w_ovf;
    logic [CNT_W-1:0]  w_cnt_inc;

    // Ready depends only on state and s_ready so upstream never sees a
    // combinational loop through p_valid.
    assign p_ready  = (r_state != HOLD) | s_ready;
    assign w_accept = p_valid & p_ready;

    // Any beat accepted outside ACC opens a fresh packet, so the running
    // totals are ignored and the beat is added to zero. This is what lets a
    // beat accepted in HOLD start the next packet without a bubble.
    assign w_start    = (r_state != ACC);
    assign w_base_acc = w_start ? '0   : r_acc;
    assign w_base_cnt = w_start ? '0   : r_cnt;
    assign w_base_sat = w_start ? 1'b0 : r_sat;
    assign w_cnt_inc  = w_base_cnt + CNT_W'(1);
    assign w_close    = p_last | (w_base_cnt == c_last_idx);

    // Once clamped at max, any nonzero addend overflows again and a zero
    // addend leaves it at max, so saturation is self-sustaining.
    sat_add_u #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_add (
        .a   (w_base_acc),
        .b   (p_data),
        .sum (w_sum),
        .ovf (w_ovf)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    w_state_nxt = w_close ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (w_accept) begin
                    w_state_nxt = w_close ? HOLD : ACC;
                end else if (s_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_sum   <= '0;
            r_s_count <= '0;
            r_s_sat   <= 1'b0;
            r_s_trunc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                if (w_close) begin
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_sat     <= 1'b0;
                    r_s_valid <= 1'b1;
                    r_s_sum   <= w_sum;
                    r_s_count <= w_cnt_inc;
                    r_s_sat   <= w_base_sat | w_ovf;
                    r_s_trunc <= ~p_last;
                end else begin
                    r_acc     <= w_sum;
                    r_cnt     <= w_cnt_inc;
                    r_sat     <= w_base_sat | w_ovf;
                    r_s_valid <= 1'b0;
                end
            end else if ((r_state == HOLD) && s_ready) begin
                r_s_valid <= 1'b0;
            end
        end
    end

    assign s_valid = r_s_valid;
    assign s_sum   = r_s_sum;
    assign s_count = r_s_count;
    assign s_sat   = r_s_sat;
    assign s_trunc = r_s_trunc;

endmodule
`default_nettype wire
